// File: rtl/ptw_axi_arbiter_pkg.sv
// Shared constants, state encoding and grant helper for the PTW AXI arbiter.
package ptw_axi_arbiter_pkg;

  // Fixed AR-channel fields for a single 8-byte PTE fetch
  localparam logic [2:0] SIZE_8B        = 3'b011;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [2:0] PROT_PRIV_DATA = 3'b001;

  // Requester indices
  localparam logic REQ_ITLB = 1'b0;
  localparam logic REQ_DTLB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } ptw_state_e;

  // Round-robin pick: on contention the requester not granted last time wins
  function automatic logic pick_grant(input logic cand_i, input logic cand_d,
                                      input logic last);
    if (cand_i && cand_d) begin
      return ~last;
    end else if (cand_d) begin
      return REQ_DTLB;
    end else begin
      return REQ_ITLB;
    end
  endfunction

endpackage

// File: rtl/ptw_req_slot.sv
// Per-requester pending latch: captures a PTE-fetch pulse (8-byte aligned
// address, last pulse wins) and presents it, or a same-cycle pulse, as a
// grant candidate. The slot empties when its candidate is granted.
module ptw_req_slot #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  grant,
  output logic                  cand,
  output logic [ADDR_WIDTH-1:0] cand_addr
);

  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] req_addr_aligned;
  logic                  unused_lsb;

  assign req_addr_aligned = {req_addr[ADDR_WIDTH-1:3], 3'b000};
  assign unused_lsb       = ^req_addr[2:0];

  // A same-cycle pulse bypasses the latch and overrides a stale address
  assign cand      = pend_q | req_valid;
  assign cand_addr = req_valid ? req_addr_aligned : addr_q;

  // Next slot state: a grant consumes both the latched and any bypassed pulse
  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    if (grant) begin
      pend_d = 1'b0;
    end else if (req_valid) begin
      pend_d = 1'b1;
      addr_d = req_addr_aligned;
    end
  end

  // Pending flag is control and is reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Captured address is only meaningful while pending
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

endmodule

// File: rtl/ptw_axi_arbiter.sv
// Shared page-table-walk read port: round-robin between ITLB and DTLB walk
// requests, one single-beat 64-bit AXI4 read outstanding at a time, PTE
// returned to the owner as a one-cycle pulse; bus errors become an
// access-fault pulse with an all-zero (invalid) PTE.
module ptw_axi_arbiter
  import ptw_axi_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int ITLB_ID    = 0,
  parameter int DTLB_ID    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ITLB_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] ITLB_ADDR,
  output logic                  ITLB_DATA_VALID,
  output logic [DATA_WIDTH-1:0] ITLB_DATA,
  output logic                  ITLB_ACCESS_FAULT,
  input  logic                  DTLB_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] DTLB_ADDR,
  output logic                  DTLB_DATA_VALID,
  output logic [DATA_WIDTH-1:0] DTLB_DATA,
  output logic                  DTLB_ACCESS_FAULT,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [ID_WIDTH-1:0]   M_ARID,
  output logic [7:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  output logic [2:0]            M_ARPROT,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST
);

  ptw_state_e                      state_q, state_d;
  logic                            owner_q, owner_d;
  logic                            last_q, last_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]           araddr_q, araddr_d;
  logic [ID_WIDTH-1:0]             arid_q, arid_d;
  logic [1:0]                      dv_q, dv_d;
  logic [1:0]                      af_q, af_d;
  logic [1:0][DATA_WIDTH-1:0]      data_q, data_d;

  logic [1:0]                      grant;
  logic                            sel;
  logic                            cand_i, cand_d;
  logic [ADDR_WIDTH-1:0]           cand_addr_i, cand_addr_d;
  logic                            unused_rsp;

  // Single beat is assumed and only RRESP[1] separates OKAY/EXOKAY from errors
  assign unused_rsp = ^{M_RLAST, M_RRESP[0]};

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_itlb_slot (
    .clk       (CLK),
    .rst       (RST),
    .req_valid (ITLB_ADDR_VALID),
    .req_addr  (ITLB_ADDR),
    .grant     (grant[REQ_ITLB]),
    .cand      (cand_i),
    .cand_addr (cand_addr_i)
  );

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_dtlb_slot (
    .clk       (CLK),
    .rst       (RST),
    .req_valid (DTLB_ADDR_VALID),
    .req_addr  (DTLB_ADDR),
    .grant     (grant[REQ_DTLB]),
    .cand      (cand_d),
    .cand_addr (cand_addr_d)
  );

  // Next-state and output logic of the IDLE -> AR -> R walk sequencer
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    dv_d      = 2'b00;
    af_d      = 2'b00;
    data_d    = data_q;
    grant     = 2'b00;
    sel       = REQ_ITLB;
    case (state_q)
      IDLE: begin
        if (cand_i || cand_d) begin
          sel        = pick_grant(cand_i, cand_d, last_q);
          grant[sel] = 1'b1;
          owner_d    = sel;
          araddr_d   = (sel == REQ_DTLB) ? cand_addr_d : cand_addr_i;
          arid_d     = (sel == REQ_DTLB) ? ID_WIDTH'(DTLB_ID) : ID_WIDTH'(ITLB_ID);
          arvalid_d  = 1'b1;
          state_d    = AR;
        end
      end
      AR: begin
        if (M_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          last_d    = owner_q;
          state_d   = R;
        end
      end
      R: begin
        if (M_RVALID && rready_q) begin
          rready_d        = 1'b0;
          dv_d[owner_q]   = 1'b1;
          af_d[owner_q]   = M_RRESP[1];
          data_d[owner_q] = M_RRESP[1] ? '0 : M_RDATA;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, AR channel and return registers; reset drops any walk in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      owner_q   <= REQ_ITLB;
      last_q    <= REQ_ITLB;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      dv_q      <= 2'b00;
      af_q      <= 2'b00;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      dv_q      <= dv_d;
      af_q      <= af_d;
      data_q    <= data_d;
    end
  end

  assign M_ARVALID = arvalid_q;
  assign M_ARADDR  = araddr_q;
  assign M_ARID    = arid_q;
  assign M_ARLEN   = 8'd0;
  assign M_ARSIZE  = SIZE_8B;
  assign M_ARBURST = BURST_INCR;
  assign M_ARPROT  = PROT_PRIV_DATA;
  assign M_RREADY  = rready_q;

  assign ITLB_DATA_VALID   = dv_q[REQ_ITLB];
  assign ITLB_ACCESS_FAULT = af_q[REQ_ITLB];
  assign ITLB_DATA         = data_q[REQ_ITLB];
  assign DTLB_DATA_VALID   = dv_q[REQ_DTLB];
  assign DTLB_ACCESS_FAULT = af_q[REQ_DTLB];
  assign DTLB_DATA         = data_q[REQ_DTLB];

endmodule

// File: tb/tb_ptw_axi_arbiter.sv
// Directed bench for ptw_axi_arbiter with a hand-driven AXI read slave.
module tb_ptw_axi_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ITLB_ADDR_VALID = 1'b0;
  logic [63:0] ITLB_ADDR = '0;
  logic        ITLB_DATA_VALID;
  logic [63:0] ITLB_DATA;
  logic        ITLB_ACCESS_FAULT;
  logic        DTLB_ADDR_VALID = 1'b0;
  logic [63:0] DTLB_ADDR = '0;
  logic        DTLB_DATA_VALID;
  logic [63:0] DTLB_DATA;
  logic        DTLB_ACCESS_FAULT;
  logic        M_ARVALID;
  logic        M_ARREADY = 1'b0;
  logic [63:0] M_ARADDR;
  logic [3:0]  M_ARID;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE;
  logic [1:0]  M_ARBURST;
  logic [2:0]  M_ARPROT;
  logic        M_RVALID = 1'b0;
  logic        M_RREADY;
  logic [63:0] M_RDATA = '0;
  logic [1:0]  M_RRESP = 2'b00;
  logic        M_RLAST = 1'b1;

  int tests = 0;
  int fails = 0;
  int ar_cnt = 0;
  int dv_cnt = 0;
  int ar_lat = 0;

  ptw_axi_arbiter dut (
    .CLK               (CLK),
    .RST               (RST),
    .ITLB_ADDR_VALID   (ITLB_ADDR_VALID),
    .ITLB_ADDR         (ITLB_ADDR),
    .ITLB_DATA_VALID   (ITLB_DATA_VALID),
    .ITLB_DATA         (ITLB_DATA),
    .ITLB_ACCESS_FAULT (ITLB_ACCESS_FAULT),
    .DTLB_ADDR_VALID   (DTLB_ADDR_VALID),
    .DTLB_ADDR         (DTLB_ADDR),
    .DTLB_DATA_VALID   (DTLB_DATA_VALID),
    .DTLB_DATA         (DTLB_DATA),
    .DTLB_ACCESS_FAULT (DTLB_ACCESS_FAULT),
    .M_ARVALID         (M_ARVALID),
    .M_ARREADY         (M_ARREADY),
    .M_ARADDR          (M_ARADDR),
    .M_ARID            (M_ARID),
    .M_ARLEN           (M_ARLEN),
    .M_ARSIZE          (M_ARSIZE),
    .M_ARBURST         (M_ARBURST),
    .M_ARPROT          (M_ARPROT),
    .M_RVALID          (M_RVALID),
    .M_RREADY          (M_RREADY),
    .M_RDATA           (M_RDATA),
    .M_RRESP           (M_RRESP),
    .M_RLAST           (M_RLAST)
  );

  always #5 CLK = ~CLK;

  // Count AR handshakes and return pulses seen at the active edge
  always @(posedge CLK) begin
    if (M_ARVALID && M_ARREADY) ar_cnt <= ar_cnt + 1;
    if (ITLB_DATA_VALID || DTLB_DATA_VALID) dv_cnt <= dv_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic vi, input logic [63:0] ai,
                       input logic vd, input logic [63:0] ad);
    ITLB_ADDR_VALID = vi;
    ITLB_ADDR       = ai;
    DTLB_ADDR_VALID = vd;
    DTLB_ADDR       = ad;
    step();
    ITLB_ADDR_VALID = 1'b0;
    DTLB_ADDR_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  // Serve one walk: expect an AR with address/ID, stall ARREADY for arw
  // cycles, return data rdl cycles after the handshake, check the return.
  // With inj set, a DTLB pulse of inj_addr arrives during the R phase.
  task automatic serve(input logic [63:0] ea, input logic [3:0] eid,
                       input logic [63:0] rd, input logic [1:0] rr,
                       input int arw, input int rdl,
                       input bit inj, input logic [63:0] inj_addr);
    int n;
    logic own_d;
    logic [63:0] exp_data;
    own_d    = (eid == 4'd1);
    exp_data = rr[1] ? 64'd0 : rd;
    M_ARREADY = 1'b0;
    n = 0;
    while (!M_ARVALID && n < 20) begin
      step();
      n++;
    end
    ar_lat = n;
    check("ar_valid_seen", M_ARVALID, 1);
    if (!M_ARVALID) return;
    check("ar_addr", M_ARADDR, ea);
    check("ar_id", M_ARID, eid);
    for (int i = 0; i < arw; i++) begin
      step();
      check("ar_hold_valid", M_ARVALID, 1);
      check("ar_hold_addr", M_ARADDR, ea);
    end
    M_ARREADY = 1'b1;
    step();
    M_ARREADY = 1'b0;
    check("ar_drop", M_ARVALID, 0);
    check("r_ready", M_RREADY, 1);
    for (int i = 0; i < rdl; i++) begin
      if (inj && i == 0) begin
        pulse(1'b0, 64'd0, 1'b1, inj_addr);
      end else begin
        step();
      end
    end
    M_RVALID = 1'b1;
    M_RDATA  = rd;
    M_RRESP  = rr;
    step();
    M_RVALID = 1'b0;
    M_RRESP  = 2'b00;
    check("ret_rready_low", M_RREADY, 0);
    check("ret_i_dv", ITLB_DATA_VALID, !own_d);
    check("ret_d_dv", DTLB_DATA_VALID, own_d);
    check("ret_i_af", ITLB_ACCESS_FAULT, !own_d && rr[1]);
    check("ret_d_af", DTLB_ACCESS_FAULT, own_d && rr[1]);
    check("ret_data", own_d ? DTLB_DATA : ITLB_DATA, exp_data);
    step();
    check("post_dv", own_d ? DTLB_DATA_VALID : ITLB_DATA_VALID, 0);
    check("post_af", own_d ? DTLB_ACCESS_FAULT : ITLB_ACCESS_FAULT, 0);
    check("post_data_hold", own_d ? DTLB_DATA : ITLB_DATA, exp_data);
  endtask

  initial begin
    int c0;
    int d0;

    // Reset state
    step();
    step();
    check("rst_arvalid", M_ARVALID, 0);
    check("rst_rready", M_RREADY, 0);
    check("rst_i_dv", ITLB_DATA_VALID, 0);
    check("rst_d_dv", DTLB_DATA_VALID, 0);
    check("rst_i_af", ITLB_ACCESS_FAULT, 0);
    check("rst_arlen", M_ARLEN, 8'd0);
    check("rst_arsize", M_ARSIZE, 3'b011);
    check("rst_arburst", M_ARBURST, 2'b01);
    check("rst_arprot", M_ARPROT, 3'b001);
    RST = 1'b0;
    step();

    // Single ITLB walk, address aligned, RVALID three cycles after AR
    c0 = ar_cnt;
    pulse(1'b1, 64'h8000_1007, 1'b0, 64'd0);
    serve(64'h8000_1000, 4'd0, 64'h2000_04CF, 2'b00, 0, 2, 1'b0, 64'd0);
    check("t1_ar_latency", ar_lat, 0);
    check("t1_one_read", ar_cnt - c0, 1);
    check("t1_d_quiet_data", DTLB_DATA, 64'd0);

    // Simultaneous requests after reset: DTLB first; a DTLB pulse while it
    // owns the port makes both pending, so ITLB wins next
    do_reset();
    pulse(1'b1, 64'h100, 1'b1, 64'h200);
    serve(64'h200, 4'd1, 64'h11, 2'b00, 0, 2, 1'b1, 64'h600);
    serve(64'h100, 4'd0, 64'h22, 2'b00, 0, 1, 1'b0, 64'd0);
    serve(64'h600, 4'd1, 64'h33, 2'b00, 0, 1, 1'b0, 64'd0);
    // Last grant was DTLB: repeated simultaneous pulses now favour ITLB
    step();
    pulse(1'b1, 64'h700, 1'b1, 64'h800);
    serve(64'h700, 4'd0, 64'h44, 2'b00, 0, 1, 1'b0, 64'd0);
    serve(64'h800, 4'd1, 64'h55, 2'b00, 0, 1, 1'b0, 64'd0);

    // ARREADY held low for five cycles
    step();
    c0 = ar_cnt;
    pulse(1'b0, 64'd0, 1'b1, 64'h123F);
    serve(64'h1238, 4'd1, 64'h66, 2'b00, 5, 1, 1'b0, 64'd0);
    check("t3_one_read", ar_cnt - c0, 1);

    // Error response on a DTLB walk
    step();
    pulse(1'b0, 64'd0, 1'b1, 64'h900);
    serve(64'h900, 4'd1, 64'hDEAD_BEEF, 2'b10, 0, 1, 1'b0, 64'd0);

    // Slot overwrite while the port is busy: only the last ITLB address read
    step();
    c0 = ar_cnt;
    pulse(1'b0, 64'd0, 1'b1, 64'hC00);
    pulse(1'b1, 64'hA00, 1'b0, 64'd0);
    pulse(1'b1, 64'hB00, 1'b0, 64'd0);
    serve(64'hC00, 4'd1, 64'h77, 2'b00, 0, 1, 1'b0, 64'd0);
    serve(64'hB00, 4'd0, 64'h88, 2'b00, 0, 1, 1'b0, 64'd0);
    step();
    step();
    check("t5_no_extra_ar", M_ARVALID, 0);
    check("t5_two_reads", ar_cnt - c0, 2);

    // Reset during R: no return pulse, then a fresh walk completes
    M_ARREADY = 1'b1;
    pulse(1'b1, 64'hD00, 1'b0, 64'd0);
    step();
    M_ARREADY = 1'b0;
    check("t6_in_r", M_RREADY, 1);
    d0 = dv_cnt;
    RST      = 1'b1;
    M_RVALID = 1'b1;
    M_RDATA  = 64'hBAD;
    step();
    RST = 1'b0;
    check("t6_rready_drop", M_RREADY, 0);
    check("t6_arvalid_drop", M_ARVALID, 0);
    step();
    step();
    M_RVALID = 1'b0;
    step();
    check("t6_no_dv", dv_cnt - d0, 0);
    check("t6_slots_clear", M_ARVALID, 0);
    pulse(1'b1, 64'hE08, 1'b0, 64'd0);
    serve(64'hE08, 4'd0, 64'h99, 2'b00, 0, 1, 1'b0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
